instruction_fetch_responder: RTL and testbench
==============================================

// Module: instruction_fetch_responder
// PURPOSE
//   Memory-side responder for the instruction fetch interface. The fetch stage issues
//   word-indexed addresses (PC steps by 1). This block returns the stored instruction
//   after a fixed, parameterised access latency, using a valid/ready handshake on each side.
//   It replaces the zero-latency combinational instruction ROM so that fetch stalls and
//   branch flushes can be exercised against a realistic memory. It includes a loader write port.
// PARAMETERS
//   WORD_WIDTH  32   instruction/address width (`WORD_WIDTH)
//   DEPTH       256  number of instruction words; valid indices 0..DEPTH-1
//   LATENCY     2    clock edges from accept to rsp_valid, counting the accepting edge; >=1
// PORTS
//   clk         in   1           rising-edge clock
//   rst         in   1           synchronous, active-high reset
//   req_valid   in   1           fetch request present
//   req_ready   out  1           responder can accept a request this cycle
//   req_addr    in   WORD_WIDTH  word index to fetch
//   flush       in   1           branch taken; discard any in-flight or pending response
//   rsp_valid   out  1           rsp_* fields hold a valid response
//   rsp_ready   in   1           consumer takes response (low = Freeze)
//   rsp_instr   out  WORD_WIDTH  fetched instruction
//   rsp_addr    out  WORD_WIDTH  address the response belongs to
//   rsp_err     out  1           req_addr was >= DEPTH
//   ld_en       in   1           loader write enable
//   ld_addr     in   WORD_WIDTH  loader word index
//   ld_data     in   WORD_WIDTH  loader write data
// BEHAVIOUR
//   States: IDLE, WAIT, RESP. Latency counter cnt has width clog2(LATENCY+1).
//   Reset (sync, highest priority): state=IDLE, cnt=0, rsp_valid=0, rsp_instr=0,
//     rsp_addr=0, rsp_err=0. Memory contents are not reset. req_ready=0 while rst=1.
//   req_ready = !rst && !flush && (state==IDLE || (state==RESP && rsp_ready)).
//   Accept = req_valid && req_ready at a rising edge. On accept:
//     - Capture rsp_addr=req_addr.
//     - If req_addr<DEPTH: rsp_instr=mem[req_addr], rsp_err=0.
//       Otherwise: rsp_instr=0, rsp_err=1.
//     - Load cnt=LATENCY-1. Next state is RESP if LATENCY==1, otherwise WAIT.
//   WAIT: at each edge, if cnt==1 go to RESP; otherwise cnt=cnt-1.
//     rsp_valid first reads 1 after the LATENCY-th edge, counting the accept edge.
//   RESP: rsp_valid=1. rsp_* fields are held stable until rsp_ready=1 at an edge.
//     Then go to IDLE, or accept a new request in the same edge (back-to-back).
//     Peak throughput is one response per LATENCY cycles.
//   Data is captured at the accept edge. Loader writes during WAIT/RESP do not change an
//     in-flight response. A same-edge write to the accepted address returns the old data.
//   Loader: ld_en=1 writes mem[ld_addr]=ld_data when ld_addr<DEPTH; otherwise ignored.
//     Active in every state, including during reset.
//   Flush (below rst, above everything else): at the edge go to IDLE, rsp_valid=0, cnt=0.
//     Any in-flight or unconsumed response is dropped. A request presented during the
//     flush cycle is not accepted. The request on the following cycle is accepted normally.
//   rsp_valid is registered: it changes only at clock edges and never in the same cycle
//     as an accept.
//   Full width compare on req_addr; no wrap-around aliasing for addresses >= DEPTH.
// TESTING
//   1. Load mem[0..3]=32'hE3A0_0001..4, LATENCY=2, rsp_ready=1, req addrs 0,1,2,3 back-to-back
//      -> 4 responses in order, each rsp_valid 2 edges after its accept, rsp_err=0.
//   2. Req addr 5 with rsp_ready=0 for 6 cycles -> rsp_valid holds 1, rsp_instr/rsp_addr=5
//      stable, req_ready=0; rsp_ready=1 -> consumed at that edge, next req accepted same edge.
//   3. Accept addr 7, flush one cycle later (in WAIT) with req_valid=1 addr 20
//      -> no response for 7, addr 20 not accepted in flush cycle; addr 20 accepted next cycle.
//   4. Req addr DEPTH (256) -> rsp_valid after LATENCY, rsp_instr=0, rsp_err=1, rsp_addr=256.
//   5. ld_en writes mem[9]=32'hDEAD_BEEF on the same edge as accept of addr 9 -> old value
//      returned; re-request addr 9 -> 32'hDEAD_BEEF.
//   6. rst asserted in WAIT and in RESP -> next cycle all outputs 0, state IDLE; memory data
//      intact; LATENCY=1 variant -> rsp_valid on the edge after accept.

Source files
------------

// File: rtl/instruction_fetch_responder.sv
// Memory-side responder for instruction fetch: returns the stored word a fixed number of
// edges after accept, with valid/ready on both sides, branch flush and a loader write port.
module instruction_fetch_responder #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_instr,
  output logic [WORD_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [WORD_WIDTH-1:0] ld_addr,
  input  logic [WORD_WIDTH-1:0] ld_data
);

  localparam int unsigned CntW  = $clog2(LATENCY + 1);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic [WORD_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  req_in_range;
  logic                  ld_in_range;
  logic                  accept;

  // Full-width compares so out-of-range addresses never alias onto a stored word.
  assign req_in_range = req_addr < WORD_WIDTH'(DEPTH);
  assign ld_in_range  = ld_addr < WORD_WIDTH'(DEPTH);
  assign rd_word      = mem[req_addr[AddrW-1:0]];

  assign req_ready = !rst && !flush &&
                     (state_q == StIdle || (state_q == StResp && rsp_ready));
  assign accept    = req_valid && req_ready;

  // Loader is deliberately outside the reset branch: it works in every state.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem[ld_addr[AddrW-1:0]] <= ld_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d     = StResp;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // An accept in RESP overrides the return to idle (back-to-back).
    if (accept) begin
      rsp_addr_d  = req_addr;
      rsp_instr_d = req_in_range ? rd_word : '0;
      rsp_err_d   = !req_in_range;
      cnt_d       = CntW'(LATENCY - 1);
      if (LATENCY == 1) begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
      end else begin
        state_d     = StWait;
        rsp_valid_d = 1'b0;
      end
    end

    if (flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Bench for instruction_fetch_responder: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_fetch_responder;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_addr = '0;
  logic         flush = 1'b0;
  logic         rsp_ready = 1'b1;
  logic         ld_en = 1'b0;
  logic [W-1:0] ld_addr = '0;
  logic [W-1:0] ld_data = '0;

  logic         req_ready, rsp_valid, rsp_err;
  logic [W-1:0] rsp_instr, rsp_addr;
  logic         req_ready1, rsp_valid1, rsp_err1;
  logic [W-1:0] rsp_instr1, rsp_addr1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_responder #(.WORD_WIDTH(W), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  instruction_fetch_responder #(.WORD_WIDTH(W), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_addr(req_addr),
    .flush(flush), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr1),
    .rsp_addr(rsp_addr1), .rsp_err(rsp_err1), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] init_word(input int i);
    if (i < 4) return 32'hE3A0_0001 + W'(i);
    return 32'h5A00_0000 ^ (W'(i) * 32'h0101_0007);
  endfunction

  // Model: one outstanding transaction, visible once enough edges have elapsed since accept.
  logic [W-1:0] mm [DEPTH];
  int           edges = 0;
  bit           busy = 1'b0;
  int           vis_at = 0;
  logic [W-1:0] m_instr = '0;
  logic [W-1:0] m_addr = '0;
  logic         m_err = 1'b0;

  function automatic bit m_visible();
    return busy && (edges >= vis_at);
  endfunction

  function automatic bit m_ready();
    return !rst && !flush && (!busy || (m_visible() && rsp_ready));
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit vis;
    acc = req_valid && m_ready();
    vis = m_visible();
    if (rst) begin
      busy    = 1'b0;
      m_instr = '0;
      m_addr  = '0;
      m_err   = 1'b0;
    end else if (flush) begin
      busy = 1'b0;
    end else begin
      if (vis && rsp_ready) busy = 1'b0;
      if (acc) begin
        busy   = 1'b1;
        vis_at = edges + LAT;
        m_addr = req_addr;
        if (req_addr < DEPTH) begin
          m_instr = mm[req_addr];
          m_err   = 1'b0;
        end else begin
          m_instr = '0;
          m_err   = 1'b1;
        end
      end
    end
    if (ld_en && ld_addr < DEPTH) mm[ld_addr] = ld_data;
    edges++;
  end

  always @(negedge clk) begin
    chk("rsp_valid", rsp_valid, m_visible());
    chk("req_ready", req_ready, m_ready());
    chk("rsp_instr", rsp_instr, m_instr);
    chk("rsp_addr", rsp_addr, m_addr);
    chk("rsp_err", rsp_err, m_err);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Fill memory while in reset; the loader must work during reset.
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = i; ld_data = init_word(i);
      tick();
    end
    ld_en = 1'b0;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_instr", rsp_instr, 0);
    rst = 1'b0;

    // 1: back-to-back fetches of 0..3, each visible two edges after its accept.
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = i;
      tick();
      chk("t1_wait_valid", rsp_valid, 0);
      tick();
      chk("t1_valid", rsp_valid, 1);
      chk("t1_instr", rsp_instr, 32'hE3A0_0001 + W'(i));
      chk("t1_addr", rsp_addr, i);
      chk("t1_err", rsp_err, 0);
    end
    req_valid = 1'b0;
    tick();
    chk("t1_drained", rsp_valid, 0);

    // 2: consumer freeze holds the response and blocks new requests.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5;
    tick();
    req_addr = 6;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t2_hold_valid", rsp_valid, 1);
      chk("t2_hold_addr", rsp_addr, 5);
      chk("t2_hold_instr", rsp_instr, init_word(5));
      chk("t2_hold_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t2_release_ready", req_ready, 1);
    tick();
    chk("t2_b2b_valid", rsp_valid, 0);
    req_valid = 1'b0;
    tick();
    chk("t2_next_addr", rsp_addr, 6);
    tick();

    // 3: flush while waiting drops addr 7; addr 20 waits until the cycle after flush.
    req_valid = 1'b1; req_addr = 7;
    tick();
    flush = 1'b1; req_addr = 20;
    #1;
    chk("t3_flush_ready", req_ready, 0);
    tick();
    chk("t3_flushed_valid", rsp_valid, 0);
    flush = 1'b0;
    tick();
    chk("t3_wait_valid", rsp_valid, 0);
    req_valid = 1'b0;
    tick();
    chk("t3_valid", rsp_valid, 1);
    chk("t3_addr", rsp_addr, 20);
    tick();

    // 4: first out-of-range address.
    req_valid = 1'b1; req_addr = DEPTH;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t4_valid", rsp_valid, 1);
    chk("t4_instr", rsp_instr, 0);
    chk("t4_err", rsp_err, 1);
    chk("t4_addr", rsp_addr, 256);
    tick();

    // 5: same-edge loader write returns old data; the next fetch sees the new word.
    req_valid = 1'b1; req_addr = 9;
    ld_en = 1'b1; ld_addr = 9; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0; req_valid = 1'b0;
    tick();
    chk("t5_old", rsp_instr, init_word(9));
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t5_new", rsp_instr, 32'hDEAD_BEEF);
    tick();

    // 6: reset in WAIT and in RESP; then the LATENCY=1 instance from a known state.
    req_valid = 1'b1; req_addr = 2;
    tick();
    rst = 1'b1; req_valid = 1'b0;
    tick();
    chk("t6w_valid", rsp_valid, 0);
    chk("t6w_instr", rsp_instr, 0);
    chk("t6w_ready", req_ready, 0);
    rst = 1'b0; req_valid = 1'b1; req_addr = 3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t6r_pre_valid", rsp_valid, 1);
    rst = 1'b1;
    tick();
    chk("t6r_valid", rsp_valid, 0);
    chk("t6r_addr", rsp_addr, 0);
    chk("t6r_err", rsp_err, 0);
    chk("t6_l1_reset_valid", rsp_valid1, 0);
    chk("t6_l1_reset_ready", req_ready1, 0);
    rst = 1'b0; req_valid = 1'b1; req_addr = 1;
    tick();
    chk("t6_l1_valid", rsp_valid1, 1);
    chk("t6_l1_instr", rsp_instr1, 32'hE3A0_0002);
    chk("t6_l1_addr", rsp_addr1, 1);
    chk("t6_l2_valid", rsp_valid, 0);
    req_valid = 1'b0;
    tick();
    chk("t6_l1_consumed", rsp_valid1, 0);
    chk("t6_l2_valid_late", rsp_valid, 1);
    tick();
    req_valid = 1'b1; req_addr = 3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t6_mem_intact", rsp_instr, 32'hE3A0_0004);
    tick();

    // Randomized traffic, checked each cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(63) == 0);
      flush     = ($urandom_range(19) == 0);
      req_valid = ($urandom_range(9) < 7);
      rsp_ready = ($urandom_range(9) < 7);
      case ($urandom_range(7))
        0:       req_addr = $urandom;
        1:       req_addr = DEPTH + $urandom_range(3);
        default: req_addr = $urandom_range(DEPTH - 1);
      endcase
      ld_en   = ($urandom_range(4) == 0);
      ld_addr = ($urandom_range(7) == 0) ? DEPTH + $urandom_range(15) : $urandom_range(DEPTH - 1);
      ld_data = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
